perf_counter_ctrl: RTL
======================

# perf_counter_ctrl

Configuration and access controller for the performance counter bank. Gates and maps raw pipeline events onto the bank's 32 event inputs, applies the global enable and per-counter inhibits, and serves CSR-side register reads and writes over a valid/ready request/response handshake. Counter values are read back through a select/data mux on the bank side. It sits between the CSR unit and the counter bank.

## Interface
- `RAW_W`, 64: number of raw event sources from the pipeline.
- `SEL_W`, 6: width of each event-select field; must satisfy 2^SEL_W ≥ RAW_W.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `raw_events` in RAW_W: one-cycle event pulses from the pipeline.
- `retire_in` in 1: instruction retired this cycle.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 8: register address.
- `req_wdata` in 32: write data.
- `resp_valid` out 1 / `resp_ready` in 1: response handshake.
- `resp_rdata` out 32: read data (0 for writes).
- `resp_err` out 1: access error.
- `cnt_sel` out 6: bank read select. 0–31 = event counter; 32 = cycle; 33 = instret.
- `cnt_rdata` in 32: bank value for `cnt_sel`. This is a combinational mux outside the block.
- `cycle_count_en` out 1, `instruction_retired` out 1, `event_signals` out 32: gated outputs to the bank.

## Operation
- Register map:
  - 0x00 CTRL:
    - [0] global enable (reset 1).
    - [1] cycle inhibit, [2] instret inhibit (reset 0).
    - [3] freeze arm, [4] frozen (RO/W1C). Both reset 0.
  - 0x01 INHIBIT[31:0]: per-slot inhibit, reset 0.
  - 0x02 FREEZE_SEL[SEL_W-1:0]: freeze trigger source, reset 0.
  - 0x10+i (i = 0..31) EVSEL[i][SEL_W-1:0]: raw source for slot i, reset value i.
  - 0x40 CYCLE (RO), 0x41 INSTRET (RO), 0x60+i EVENT[i] (RO): read from the bank.
- Unused register bits read 0 and ignore writes.
- Error responses (`resp_err` = 1, no state change, rdata 0):
  - Write to 0x40, 0x41 or 0x60–0x7F.
  - Any access to an unmapped address.
- If EVSEL[i] ≥ RAW_W, slot i never fires. This is not an error.
- Gating, registered one stage. Let `act` = enable & !frozen:
  - `event_signals[i]` ← act & !INHIBIT[i] & raw_events[EVSEL[i]].
  - `cycle_count_en` ← act & !CTRL[1].
  - `instruction_retired` ← act & !CTRL[2] & retire_in.
- FSM states: IDLE, CNT_RD, RESP.
  - IDLE: `req_ready` = 1.
    - Config write/read or error: accepted at edge → RESP.
    - Counter read: accepted at edge → CNT_RD, with `cnt_sel` driven from the address.
  - CNT_RD: one cycle. `cnt_rdata` is captured into `resp_rdata` at its end → RESP.
  - RESP: `resp_valid` = 1, data held stable until `resp_ready` is sampled high → IDLE. `req_ready` = 0 outside IDLE.
- One request outstanding at a time. A request is never accepted in the same cycle as a response completes.
- `cnt_sel` holds its last value outside CNT_RD.

## Timing
- Reset values: `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `cnt_sel` 0, all gated outputs 0, FSM IDLE. Registers take the reset values listed above.
- Reset in any state drops the pending request or response. The next cycle is IDLE.
- Config write: takes effect at the acceptance edge. The gated output registered on that same edge still uses the old config; the new config governs the following edge.
- Response latency from acceptance edge N:
  - Config access or error: `resp_valid` high in cycle N+1.
  - Counter read: `resp_valid` high in cycle N+2.
- Event to gated output: 1 cycle. Event to counter increment: 2 cycles.
- Counter read returns the value present in cycle N+1. No atomic snapshot across counters.

## Configuration
- `PERF_CTRL_FREEZE_EN` defined:
  - When CTRL[3] = 1 and raw_events[FREEZE_SEL] = 1 at an edge, frozen is set at that edge.
  - Gated outputs are forced 0 starting the cycle after frozen is set. The trigger-cycle events are still counted.
  - Writing 1 to CTRL[4] clears frozen; arm is unaffected.
  - Simultaneous trigger and clear: set wins.
- `PERF_CTRL_FREEZE_EN` undefined:
  - CTRL[4:3] and FREEZE_SEL read 0; writes to them are ignored without error.
  - frozen is constant 0.

## Test plan
- Reset, then read CTRL, EVSEL[5] and INHIBIT → 0x1, 0x5 and 0x0, each with `resp_valid` one cycle after acceptance.
- Write EVSEL[3] = 40, pulse raw_events[40] → `event_signals[3]` high exactly one cycle later; `event_signals[40 mod 32]` unaffected.
- Set INHIBIT = 0x8 and CTRL[1] = 1, run 10 cycles → `event_signals[3]` and `cycle_count_en` stay 0; instret still passes.
- Read 0x41 with `cnt_rdata` = 0x1234 for cnt_sel 33 → `cnt_sel` = 33 in CNT_RD, `resp_rdata` = 0x1234 two cycles after acceptance. Stall `resp_ready` 3 cycles → data holds and `req_ready` stays 0.
- Write 0x60 → `resp_err` = 1 and no state change. Read 0x03 → `resp_err` = 1, rdata 0.
- Freeze, with the macro defined: arm, FREEZE_SEL = 7, pulse raw_events[7] → CTRL[4] = 1 and gated outputs 0 from the next cycle. Write CTRL with bit 4 = 1 → counting resumes.

Source files
------------

// File: rtl/perf_counter_ctrl.sv
// Performance counter controller: event gating/mapping onto the bank plus CSR access FSM.
// Optional freeze-on-event support is compiled in with `define PERF_CTRL_FREEZE_EN.
module perf_counter_ctrl #(
  parameter int unsigned RAW_W = 64,
  parameter int unsigned SEL_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RAW_W-1:0]  raw_events,
  input  logic              retire_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [7:0]        req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [5:0]        cnt_sel,
  input  logic [31:0]       cnt_rdata,
  output logic              cycle_count_en,
  output logic              instruction_retired,
  output logic [31:0]       event_signals
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCntRd = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  localparam int unsigned SelN = 2 ** SEL_W;

  logic [1:0]       state_q;
  logic             en_q, cyc_inh_q, ir_inh_q;
  logic [31:0]      inhibit_q;
  logic [SEL_W-1:0] evsel_q [32];
  logic             frozen;

  // Selects at or above RAW_W land in the zero padding and never fire.
  logic [SelN-1:0] raw_pad;
  assign raw_pad = SelN'(raw_events);

  // Address decode
  logic       is_ctrl, is_inh, is_fsel, is_evsel, is_cnt, cfg_hit;
  logic [4:0] ev_idx;
  logic [5:0] cnt_idx;
  always_comb begin
    is_ctrl  = (req_addr == 8'h00);
    is_inh   = (req_addr == 8'h01);
    is_fsel  = (req_addr == 8'h02);
    is_evsel = (req_addr >= 8'h10) && (req_addr <= 8'h2f);
    is_cnt   = (req_addr == 8'h40) || (req_addr == 8'h41) || (req_addr[7:5] == 3'b011);
    cfg_hit  = is_ctrl || is_inh || is_fsel || is_evsel;
    ev_idx   = 5'(req_addr - 8'h10);
    if (req_addr == 8'h40)      cnt_idx = 6'd32;
    else if (req_addr == 8'h41) cnt_idx = 6'd33;
    else                        cnt_idx = {1'b0, req_addr[4:0]};
  end

  logic accept, cfg_we;
  assign accept = (state_q == StIdle) && req_valid;
  assign cfg_we = accept && req_write && cfg_hit;

`ifdef PERF_CTRL_FREEZE_EN
  logic             arm_q;
  logic [SEL_W-1:0] freeze_sel_q;
  logic             frozen_q;
  logic             frz_set, frz_clr;
  assign frozen  = frozen_q;
  assign frz_set = arm_q && raw_pad[freeze_sel_q];
  assign frz_clr = cfg_we && is_ctrl && req_wdata[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q        <= 1'b0;
      freeze_sel_q <= '0;
      frozen_q     <= 1'b0;
    end else begin
      if (cfg_we && is_ctrl) arm_q <= req_wdata[3];
      if (cfg_we && is_fsel) freeze_sel_q <= req_wdata[SEL_W-1:0];
      frozen_q <= frz_set || (frozen_q && !frz_clr);
    end
  end
`else
  assign frozen = 1'b0;
`endif

  logic [31:0] cfg_rdata;
  always_comb begin
    cfg_rdata = '0;
    if (is_ctrl) begin
      cfg_rdata[2:0] = {ir_inh_q, cyc_inh_q, en_q};
`ifdef PERF_CTRL_FREEZE_EN
      cfg_rdata[4:3] = {frozen_q, arm_q};
`endif
    end else if (is_inh) begin
      cfg_rdata = inhibit_q;
    end else if (is_fsel) begin
`ifdef PERF_CTRL_FREEZE_EN
      cfg_rdata = 32'(freeze_sel_q);
`endif
    end else if (is_evsel) begin
      cfg_rdata = 32'(evsel_q[ev_idx]);
    end
  end

  // Gating uses the config as it stands before this edge's write.
  logic        act;
  logic [31:0] ev_d;
  assign act = en_q && !frozen;
  always_comb begin
    ev_d = '0;
    for (int i = 0; i < 32; i++) begin
      ev_d[i] = act && !inhibit_q[i] && raw_pad[evsel_q[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= StIdle;
      resp_rdata          <= '0;
      resp_err            <= 1'b0;
      cnt_sel             <= '0;
      en_q                <= 1'b1;
      cyc_inh_q           <= 1'b0;
      ir_inh_q            <= 1'b0;
      inhibit_q           <= '0;
      for (int i = 0; i < 32; i++) evsel_q[i] <= SEL_W'(i);
      event_signals       <= '0;
      cycle_count_en      <= 1'b0;
      instruction_retired <= 1'b0;
    end else begin
      event_signals       <= ev_d;
      cycle_count_en      <= act && !cyc_inh_q;
      instruction_retired <= act && !ir_inh_q && retire_in;

      if (cfg_we && is_ctrl) begin
        en_q      <= req_wdata[0];
        cyc_inh_q <= req_wdata[1];
        ir_inh_q  <= req_wdata[2];
      end
      if (cfg_we && is_inh)   inhibit_q <= req_wdata;
      if (cfg_we && is_evsel) evsel_q[ev_idx] <= req_wdata[SEL_W-1:0];

      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (is_cnt && !req_write) begin
              cnt_sel  <= cnt_idx;
              resp_err <= 1'b0;
              state_q  <= StCntRd;
            end else begin
              resp_err   <= !cfg_hit;
              resp_rdata <= (cfg_hit && !req_write) ? cfg_rdata : 32'h0;
              state_q    <= StResp;
            end
          end
        end
        StCntRd: begin
          resp_rdata <= cnt_rdata;
          state_q    <= StResp;
        end
        StResp: begin
          if (resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);

endmodule
